// File: rtl/door_pkg.sv
// Shared definitions for the door latch controller.
//   state_t        : controller state encoding (3 bits; values 6 and 7 are illegal
//                    and recover to LOCKED).
//   counter_width  : width of the down-counter needed to hold the larger of the
//                    actuator pulse length and the open timeout.
package door_pkg;

    typedef enum logic [2:0] {
        LOCKED    = 3'd0,
        RELEASE   = 3'd1,
        OPEN_WAIT = 3'd2,
        DOOR_OPEN = 3'd3,
        ENGAGE    = 3'd4,
        ALARM     = 3'd5
    } state_t;

    // The counter is loaded with (value - 1), so max(a, b) + 1 always fits.
    // The result is at least 1 for any legal parameters.
    function automatic int counter_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/door_latch_ctrl_if.sv
// Signal bundle between the door latch controller and its surroundings.
//   unlock       : one-cycle strobe from the code-entry FSM.
//   door_open    : synchronised door sensor, 1 = door physically open.
//   bolt_retract : actuator drive to withdraw the bolt.
//   bolt_extend  : actuator drive to throw the bolt.
//   unlocked     : status, bolt withdrawn and door may be opened.
//   alarm        : forced-entry alarm.
//   state        : current controller state, for observation only.
// Modports: master drives the inputs and observes the outputs; slave is the
// controller itself.
//
// There is no valid/ready handshake on this bundle: unlock is a single-cycle
// strobe that is acted upon in the cycle it is sampled or dropped, never held
// or queued; door_open is a level that is sampled every posedge.
interface door_latch_ctrl_if;

    logic              unlock;
    logic              door_open;
    logic              bolt_retract;
    logic              bolt_extend;
    logic              unlocked;
    logic              alarm;
    door_pkg::state_t  state;

    modport master (
        output unlock,
        output door_open,
        input  bolt_retract,
        input  bolt_extend,
        input  unlocked,
        input  alarm,
        input  state
    );

    modport slave (
        input  unlock,
        input  door_open,
        output bolt_retract,
        output bolt_extend,
        output unlocked,
        output alarm,
        output state
    );

endinterface

// File: rtl/door_latch_ctrl_cycle_timer.sv
// Loadable down-counter that saturates at zero.
//   clk      : system clock.
//   reset    : synchronous active-low reset, clears the count.
//   load     : load load_val this cycle (takes priority over en).
//   load_val : value to load.
//   en       : decrement by one when the count is non-zero.
//   zero     : count is zero.
module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/door_latch_ctrl.sv
// Door bolt controller downstream of the serial-code lock.
// Retracts the bolt for ACT_CYCLES after an unlock strobe, keeps the door
// unlocked for OPEN_TIMEOUT cycles (or while it is open), then throws the bolt
// for ACT_CYCLES. Opening the door while locked latches an alarm that is only
// cleared by an unlock with the door closed.
//   clk   : system clock, all state changes on posedge.
//   reset : synchronous active-low reset.
//   bus   : slave side of door_latch_ctrl_if (unlock/door_open in, actuator
//           drives, status and state out).
// Parameters ACT_CYCLES and OPEN_TIMEOUT must both be >= 1.
module door_latch_ctrl
    import door_pkg::*;
#(
    parameter int ACT_CYCLES   = 4,
    parameter int OPEN_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    door_latch_ctrl_if.slave   bus
);

    localparam int CW = counter_width(ACT_CYCLES, OPEN_TIMEOUT);
    localparam logic [CW-1:0] ACT_LOAD  = CW'(ACT_CYCLES - 1);
    localparam logic [CW-1:0] OPEN_LOAD = CW'(OPEN_TIMEOUT - 1);

    state_t          state_q;
    state_t          state_d;
    logic            tmr_load;
    logic [CW-1:0]   tmr_load_val;
    logic            tmr_en;
    logic            tmr_zero;

    cycle_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and timer control. Every transition reloads the timer; states
    // without a duration load zero. A timed state lasts (load + 1) cycles
    // because it leaves in the cycle the count is seen at zero.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        case (state_q)
            LOCKED: begin
                // A door found open while locked wins over a simultaneous unlock.
                if (bus.door_open) begin
                    state_d  = ALARM;
                    tmr_load = 1'b1;
                end else if (bus.unlock) begin
                    state_d      = RELEASE;
                    tmr_load     = 1'b1;
                    tmr_load_val = ACT_LOAD;
                end
            end
            RELEASE: begin
                if (tmr_zero) begin
                    state_d      = OPEN_WAIT;
                    tmr_load     = 1'b1;
                    tmr_load_val = OPEN_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            OPEN_WAIT: begin
                if (bus.door_open) begin
                    state_d  = DOOR_OPEN;
                    tmr_load = 1'b1;
                end else if (bus.unlock) begin
                    // A repeated valid code restarts the full open window.
                    tmr_load     = 1'b1;
                    tmr_load_val = OPEN_LOAD;
                end else if (tmr_zero) begin
                    state_d      = ENGAGE;
                    tmr_load     = 1'b1;
                    tmr_load_val = ACT_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (!bus.door_open) begin
                    state_d      = ENGAGE;
                    tmr_load     = 1'b1;
                    tmr_load_val = ACT_LOAD;
                end
            end
            ENGAGE: begin
                // Never throw the bolt into an open door: abort the pulse.
                if (bus.door_open) begin
                    state_d  = DOOR_OPEN;
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = LOCKED;
                    tmr_load = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ALARM: begin
                if (bus.unlock && !bus.door_open) begin
                    state_d  = LOCKED;
                    tmr_load = 1'b1;
                end
            end
            default: begin
                state_d  = LOCKED;
                tmr_load = 1'b1;
            end
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        bus.bolt_retract = 1'b0;
        bus.bolt_extend  = 1'b0;
        bus.unlocked     = 1'b0;
        bus.alarm        = 1'b0;
        case (state_q)
            RELEASE:   bus.bolt_retract = 1'b1;
            OPEN_WAIT: bus.unlocked     = 1'b1;
            DOOR_OPEN: bus.unlocked     = 1'b1;
            ENGAGE:    bus.bolt_extend  = 1'b1;
            ALARM:     bus.alarm        = 1'b1;
            default: begin
            end
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_door_latch_ctrl.sv
// Self-checking bench for door_latch_ctrl with default parameters.
// Each scenario starts from a 2-cycle reset; cycle c is the interval ending at
// posedge c, inputs for cycle c are sampled at posedge c and their effect is
// expected in cycle c+1. Outputs are packed {bolt_retract, bolt_extend,
// unlocked, alarm}.
module tb_door_latch_ctrl;
    import door_pkg::*;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] RET  = 4'b1000;
    localparam logic [3:0] EXT  = 4'b0100;
    localparam logic [3:0] UNL  = 4'b0010;
    localparam logic [3:0] ALM  = 4'b0001;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [3:0] exp_q[$];

    door_latch_ctrl_if bus ();

    door_latch_ctrl #(
        .ACT_CYCLES   (4),
        .OPEN_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {bus.bolt_retract, bus.bolt_extend, bus.unlocked, bus.alarm};
    endfunction

    // driver: apply inputs for one cycle and queue the expected outputs
    task automatic drive(input logic rst_n, input logic unl, input logic dopen,
                         input logic [3:0] e);
        reset         = rst_n;
        bus.unlock    = unl;
        bus.door_open = dopen;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        logic [3:0] e;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NONE);
            got = outs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset_outs cyc=%0d got=%b exp=%b", c + 1, got, e);
            end
            total++;
            if (bus.state !== LOCKED) begin
                bad++;
                $display("FAIL reset_state cyc=%0d got=%0d exp=%0d", c + 1, bus.state, LOCKED);
            end
        end
    endtask

    task automatic test_auto_relock();
        logic [3:0] got;
        logic [3:0] e;
        int k;
        for (int c = 0; c <= 40; c++) begin
            k = c + 1;
            e = NONE;
            if (k >= 11 && k <= 14) e = RET;
            if (k >= 15 && k <= 30) e = UNL;
            if (k >= 31 && k <= 34) e = EXT;
            drive(c >= 2, c == 10, 1'b0, e);
            got = outs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL auto_relock cyc=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_normal_entry();
        logic [3:0] got;
        logic [3:0] e;
        int k;
        for (int c = 0; c <= 50; c++) begin
            k = c + 1;
            e = NONE;
            if (k >= 11 && k <= 14) e = RET;
            if (k >= 15 && k <= 41) e = UNL;
            if (k >= 42 && k <= 45) e = EXT;
            drive(c >= 2, c == 10, c >= 20 && c <= 40, e);
            got = outs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL normal_entry cyc=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_forced_entry();
        logic [3:0] got;
        logic [3:0] e;
        int k;
        for (int c = 0; c <= 20; c++) begin
            k = c + 1;
            e = (k >= 6 && k <= 15) ? ALM : NONE;
            drive(c >= 2, c == 9 || c == 15, c >= 5 && c <= 11, e);
            got = outs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL forced_entry cyc=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_timeout_extend();
        logic [3:0] got;
        logic [3:0] e;
        int k;
        for (int c = 0; c <= 44; c++) begin
            k = c + 1;
            e = NONE;
            if (k >= 11 && k <= 14) e = RET;
            if (k >= 15 && k <= 36) e = UNL;
            if (k >= 37 && k <= 40) e = EXT;
            drive(c >= 2, c == 10 || c == 20, 1'b0, e);
            got = outs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL timeout_extend cyc=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    // Door opened 16-19, closed at 20 (extend starts 21), re-opened at 22
    // (second extend cycle), closed again at 26 for a full extend pulse.
    task automatic test_reopen_engage();
        logic [3:0] got;
        logic [3:0] e;
        int k;
        for (int c = 0; c <= 34; c++) begin
            k = c + 1;
            e = NONE;
            if (k >= 11 && k <= 14) e = RET;
            if (k >= 15 && k <= 20) e = UNL;
            if (k >= 21 && k <= 22) e = EXT;
            if (k >= 23 && k <= 26) e = UNL;
            if (k >= 27 && k <= 30) e = EXT;
            drive(c >= 2, c == 10, (c >= 16 && c <= 19) || (c >= 22 && c <= 25), e);
            got = outs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reopen_engage cyc=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    // Reset lands in the second retract cycle; a later unlock must give a full
    // 4-cycle retract pulse.
    task automatic test_reset_mid();
        logic [3:0] got;
        logic [3:0] e;
        int k;
        for (int c = 0; c <= 27; c++) begin
            k = c + 1;
            e = NONE;
            if (k >= 11 && k <= 12) e = RET;
            if (k >= 21 && k <= 24) e = RET;
            if (k >= 25) e = UNL;
            drive(c >= 2 && c != 12, c == 10 || c == 20, 1'b0, e);
            got = outs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] got;
        logic [3:0] e;
        int k;
        for (int c = 0; c <= 12; c++) begin
            k = c + 1;
            e = (k >= 6) ? ALM : NONE;
            drive(c >= 2, c == 5, c >= 5 && c <= 7, e);
            got = outs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL simultaneous cyc=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        bus.unlock    = 1'b0;
        bus.door_open = 1'b0;
        test_reset();
        test_auto_relock();
        test_normal_entry();
        test_forced_entry();
        test_timeout_extend();
        test_reopen_engage();
        test_reset_mid();
        test_simultaneous();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/door_latch_ctrl.md
Name: door_latch_ctrl

Overview:
- Downstream consumer of the serial-code lock FSM's one-cycle `unlock` strobe.
- Drives the door bolt actuator: retract pulse, hold-open window, re-lock pulse.
- Monitors a door-position sensor and raises an alarm on forced entry.
- Moore-style controller plus one down-counter; all outputs are decoded from registered state.

Parameters:
- ACT_CYCLES, 4: width in cycles of each bolt actuator pulse (retract or extend); must be >= 1.
- OPEN_TIMEOUT, 16: cycles the door stays unlocked waiting to be opened before auto re-lock; must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- unlock  in  1  one-cycle strobe from the code-entry FSM; a valid code was entered.
- door_open  in  1  door sensor, already synchronised; 1 = door physically open.
- bolt_retract  out  1  actuator drive to withdraw the bolt.
- bolt_extend  out  1  actuator drive to throw the bolt.
- unlocked  out  1  status: the bolt is withdrawn and the door may be opened.
- alarm  out  1  forced-entry alarm.

Behaviour:
- Reset (reset==0 at posedge): state=LOCKED, counter=0. bolt_retract=0, bolt_extend=0, unlocked=0, alarm=0 from the following cycle. Reset overrides every other input in any state, including mid-pulse.
- Inputs are sampled at posedge N. The new state and its outputs are visible from cycle N+1. Outputs are pure functions of the state register.
- Counter: down-counter, width $clog2(max(ACT_CYCLES,OPEN_TIMEOUT)+1). It is loaded on each state entry and decrements in RELEASE, OPEN_WAIT and ENGAGE. It never wraps: it holds at 0.
- States and outputs:
  - LOCKED: all outputs 0.
  - RELEASE: bolt_retract=1.
  - OPEN_WAIT: unlocked=1.
  - DOOR_OPEN: unlocked=1.
  - ENGAGE: bolt_extend=1.
  - ALARM: alarm=1.
- LOCKED:
  - door_open=1 -> ALARM. This wins over a simultaneous unlock.
  - else unlock=1 -> RELEASE, counter loaded with ACT_CYCLES-1.
- RELEASE:
  - Lasts exactly ACT_CYCLES cycles, then -> OPEN_WAIT with counter loaded OPEN_TIMEOUT-1.
  - unlock and door_open are ignored during this state.
- OPEN_WAIT:
  - door_open=1 -> DOOR_OPEN.
  - else unlock=1 -> reload counter to OPEN_TIMEOUT-1 and stay.
  - else counter==0 -> ENGAGE, counter loaded ACT_CYCLES-1.
  - Without intervention, unlocked is high for exactly OPEN_TIMEOUT cycles.
- DOOR_OPEN:
  - No timeout.
  - door_open=0 -> ENGAGE, counter loaded ACT_CYCLES-1.
  - unlock is ignored.
- ENGAGE:
  - door_open=1 (door re-opened before the bolt is thrown) -> DOOR_OPEN, pulse aborted.
  - else lasts exactly ACT_CYCLES cycles, then -> LOCKED.
  - A simultaneous unlock is ignored.
- ALARM:
  - Sticky.
  - unlock=1 with door_open=0 -> LOCKED (disarm).
  - unlock while door_open=1 is ignored.
- Invariant: bolt_retract and bolt_extend are never high in the same cycle. unlocked and alarm are never high in the same cycle.
- Unencoded or illegal state value -> LOCKED on the next posedge.

Decomposition:
- Package door_pkg: state enum (LOCKED, RELEASE, OPEN_WAIT, DOOR_OPEN, ENGAGE, ALARM) and a helper function computing the counter width.
- Sub-module cycle_timer: loadable down-counter with `load`, `load_val`, `en`, and `zero` outputs; saturates at 0.
- door_latch_ctrl instantiates cycle_timer once and holds the state register plus next-state and output decode.

Test Plan:
- Release then auto re-lock (defaults): reset low 2 cycles, then unlock pulse at cycle 10.
  - bolt_retract=1 on cycles 11-14.
  - unlocked=1 on cycles 15-30.
  - bolt_extend=1 on cycles 31-34.
  - All outputs 0 from cycle 35.
- Normal entry: unlock at cycle 10; door_open high cycles 20-40.
  - unlocked=1 on cycles 15-41.
  - bolt_extend=1 on cycles 42-45.
  - No alarm at any point.
- Forced entry and disarm: door_open=1 at cycle 5 while LOCKED -> alarm=1 from cycle 6.
  - unlock at cycle 9 with door open -> alarm stays 1.
  - door_open=0 at cycle 12, unlock at cycle 15 -> alarm=0 from cycle 16.
- Timeout extension: unlock at 10, second unlock at 20 (in OPEN_WAIT).
  - unlocked stays 1 through cycle 36.
  - bolt_extend=1 on cycles 37-40.
- Re-open during ENGAGE: door closes so bolt_extend starts, then door_open=1 in the 2nd extend cycle.
  - bolt_extend drops the next cycle; unlocked=1.
  - On final close, a full 4-cycle extend pulse is produced.
- Reset mid-operation: assert reset during RELEASE (bolt_retract=1).
  - All outputs 0 the next cycle.
  - A later unlock produces a full 4-cycle retract pulse.
  - Simultaneous unlock+door_open in LOCKED -> ALARM, no bolt_retract.
